// File: rtl/fifo_mem.sv
// Simple dual-port register array: synchronous write, registered read with read-enable.
// A read and write to the same address in one cycle returns the old word.
module fifo_mem #(
  parameter int B = 8,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         we,
  input  logic [W-1:0] waddr,
  input  logic [B-1:0] wdata,
  input  logic         re,
  input  logic [W-1:0] raddr,
  output logic [B-1:0] rdata
);

  logic [B-1:0] mem [2**W];
  logic [B-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Output register is zeroed by reset/flush; the array itself is never cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_reg <= '0;
    else if (clr) rdata_reg <= '0;
    else if (re) rdata_reg <= mem[raddr];
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/fifo_lvl.sv
// Synchronous FIFO with occupancy level, almost flags, sticky error flags,
// flush, and selectable standard / first-word-fall-through read mode.
module fifo_lvl #(
  parameter int    B      = 8,
  parameter int    W      = 4,
  parameter int    FWFT   = 0,
  parameter int    AF_LVL = (2**W) - 1,
  parameter int    AE_LVL = 1,
  parameter string NAME   = ""
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_wr,
  input  logic [B-1:0] i_data,
  input  logic         i_rd,
  output logic [B-1:0] o_data,
  output logic         o_empty_n,
  output logic         o_full,
  output logic [W:0]   o_level,
  output logic         o_almost_full,
  output logic         o_almost_empty,
  output logic         o_ovf,
  output logic         o_udf
);

  localparam int DEPTH = 2**W;
  localparam int LW    = W + 1;

  logic [LW-1:0] level_reg, level_next;
  logic [W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [W-1:0]  rd_ptr_reg, rd_ptr_next;
  logic          ovf_reg, ovf_next;
  logic          udf_reg, udf_next;

  logic          empty_n, full;
  logic          rd_ok, wr_ok, rd_acc, wr_acc;
  logic          mem_we, mem_re;
  logic [B-1:0]  mem_q;

  assign empty_n = (level_reg != '0);
  assign full    = (level_reg == LW'(DEPTH));

  // Acceptance is judged on registered state; a flush suppresses both requests.
  assign rd_ok  = i_rd & empty_n;
  assign wr_ok  = i_wr & (~full | rd_ok);
  assign rd_acc = rd_ok & ~i_clr;
  assign wr_acc = wr_ok & ~i_clr;

  always_comb begin
    level_next  = level_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    ovf_next    = ovf_reg;
    udf_next    = udf_reg;
    if (i_clr) begin
      level_next  = '0;
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      ovf_next    = 1'b0;
      udf_next    = 1'b0;
    end else begin
      level_next = level_reg + LW'(wr_acc) - LW'(rd_acc);
      if (mem_we) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (mem_re) rd_ptr_next = rd_ptr_reg + 1'b1;
      if (i_wr & ~wr_ok) ovf_next = 1'b1;
      if (i_rd & ~empty_n) udf_next = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      level_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      ovf_reg    <= 1'b0;
      udf_reg    <= 1'b0;
    end else begin
      level_reg  <= level_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      ovf_reg    <= ovf_next;
      udf_reg    <= udf_next;
    end
  end

  fifo_mem #(.B(B), .W(W)) u_mem (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .clr   (i_clr),
    .we    (mem_we),
    .waddr (wr_ptr_reg),
    .wdata (i_data),
    .re    (mem_re),
    .raddr (rd_ptr_reg),
    .rdata (mem_q)
  );

  generate
    if (FWFT != 0) begin : g_fwft
      // The head word lives either in the bypass register (written straight from
      // i_data when the FIFO has nothing else) or in the memory read register.
      logic         byp_sel_reg;
      logic [B-1:0] byp_data_reg;
      logic         bypass;

      assign bypass = wr_acc & ((level_reg == '0) | (rd_acc & (level_reg == LW'(1))));
      assign mem_we = wr_acc & ~bypass;
      assign mem_re = rd_acc & (level_reg > LW'(1));

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          byp_sel_reg  <= 1'b1;
          byp_data_reg <= '0;
        end else if (i_clr) begin
          byp_sel_reg  <= 1'b1;
          byp_data_reg <= '0;
        end else if (bypass) begin
          byp_sel_reg  <= 1'b1;
          byp_data_reg <= i_data;
        end else if (mem_re) begin
          byp_sel_reg  <= 1'b0;
        end
      end

      assign o_data = byp_sel_reg ? byp_data_reg : mem_q;
    end else begin : g_std
      assign mem_we = wr_acc;
      assign mem_re = rd_acc;
      assign o_data = mem_q;
    end
  endgenerate

  assign o_empty_n      = empty_n;
  assign o_full         = full;
  assign o_level        = level_reg;
  assign o_almost_full  = (32'(level_reg) >= AF_LVL);
  assign o_almost_empty = (32'(level_reg) <= AE_LVL);
  assign o_ovf          = ovf_reg;
  assign o_udf          = udf_reg;

`ifndef SYNTHESIS
  initial begin
    if (AF_LVL < 0 || AF_LVL > DEPTH || AE_LVL < 0 || AE_LVL >= DEPTH)
      $error("fifo_lvl %s: bad thresholds AF_LVL=%0d AE_LVL=%0d DEPTH=%0d",
             NAME, AF_LVL, AE_LVL, DEPTH);
  end

  always @(posedge i_clk) begin
    if (i_rst_n && (level_next != level_reg || wr_ptr_next != wr_ptr_reg ||
        rd_ptr_next != rd_ptr_reg || ovf_next != ovf_reg || udf_next != udf_reg))
      $display("[%s] wr_ptr=%0d rd_ptr=%0d level=%0d ovf=%b udf=%b",
               NAME, wr_ptr_next, rd_ptr_next, level_next, ovf_next, udf_next);
  end
`endif

endmodule

// File: tb/tb_fifo_lvl.sv
// Directed bench for fifo_lvl: a standard-mode instance driven from a vector table
// and a FWFT instance driven by hand-written sequences, both W=2, AF_LVL=3, AE_LVL=1.
module tb_fifo_lvl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_clr = 0, a_wr = 0, a_rd = 0;
  logic [7:0] a_din = 0;
  logic [7:0] a_data;
  logic       a_en, a_full, a_af, a_ae, a_ovf, a_udf;
  logic [2:0] a_lvl;

  logic       b_clr = 0, b_wr = 0, b_rd = 0;
  logic [7:0] b_din = 0;
  logic [7:0] b_data;
  logic       b_en, b_full, b_af, b_ae, b_ovf, b_udf;
  logic [2:0] b_lvl;

  fifo_lvl #(.B(8), .W(2), .FWFT(0), .AF_LVL(3), .AE_LVL(1), .NAME("std")) u_std (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(a_clr), .i_wr(a_wr), .i_data(a_din),
    .i_rd(a_rd), .o_data(a_data), .o_empty_n(a_en), .o_full(a_full),
    .o_level(a_lvl), .o_almost_full(a_af), .o_almost_empty(a_ae),
    .o_ovf(a_ovf), .o_udf(a_udf)
  );

  fifo_lvl #(.B(8), .W(2), .FWFT(1), .AF_LVL(3), .AE_LVL(1), .NAME("fwft")) u_fwft (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(b_clr), .i_wr(b_wr), .i_data(b_din),
    .i_rd(b_rd), .o_data(b_data), .o_empty_n(b_en), .o_full(b_full),
    .o_level(b_lvl), .o_almost_full(b_af), .o_almost_empty(b_ae),
    .o_ovf(b_ovf), .o_udf(b_udf)
  );

  // Packed status: {data, empty_n, full, level, af, ae, ovf, udf}
  logic [16:0] a_st, b_st;
  assign a_st = {a_data, a_en, a_full, a_lvl, a_af, a_ae, a_ovf, a_udf};
  assign b_st = {b_data, b_en, b_full, b_lvl, b_af, b_ae, b_ovf, b_udf};

  typedef struct packed {
    logic        clr;
    logic        wr;
    logic        rd;
    logic [7:0]  din;
    logic [16:0] exp;
  } vec_t;

  int checks = 0;
  int errors = 0;

  function automatic logic [16:0] ex(input logic [7:0] d, input logic en, input logic fl,
                                     input logic [2:0] lv, input logic af, input logic ae,
                                     input logic ov, input logic ud);
    return {d, en, fl, lv, af, ae, ov, ud};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end else begin
      $display("ok   %s: %0h", nm, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic c, input logic w, input logic r, input logic [7:0] d);
    a_clr = c; a_wr = w; a_rd = r; a_din = d;
  endtask

  task automatic set_b(input logic c, input logic w, input logic r, input logic [7:0] d);
    b_clr = c; b_wr = w; b_rd = r; b_din = d;
  endtask

  vec_t vecs[$];

  initial begin
    // Standard-mode table: {clr, wr, rd, din, expected status after the edge}
    vecs.push_back({1'b0, 1'b1, 1'b0, 8'h11, ex(8'h00, 1, 0, 3'd1, 0, 1, 0, 0)});
    vecs.push_back({1'b0, 1'b1, 1'b0, 8'h22, ex(8'h00, 1, 0, 3'd2, 0, 0, 0, 0)});
    vecs.push_back({1'b0, 1'b1, 1'b0, 8'h33, ex(8'h00, 1, 0, 3'd3, 1, 0, 0, 0)});
    vecs.push_back({1'b0, 1'b1, 1'b0, 8'h44, ex(8'h00, 1, 1, 3'd4, 1, 0, 0, 0)});
    vecs.push_back({1'b0, 1'b1, 1'b0, 8'h55, ex(8'h00, 1, 1, 3'd4, 1, 0, 1, 0)});
    vecs.push_back({1'b0, 1'b0, 1'b1, 8'h00, ex(8'h11, 1, 0, 3'd3, 1, 0, 1, 0)});
    vecs.push_back({1'b0, 1'b0, 1'b1, 8'h00, ex(8'h22, 1, 0, 3'd2, 0, 0, 1, 0)});
    vecs.push_back({1'b0, 1'b0, 1'b1, 8'h00, ex(8'h33, 1, 0, 3'd1, 0, 1, 1, 0)});
    vecs.push_back({1'b0, 1'b0, 1'b1, 8'h00, ex(8'h44, 0, 0, 3'd0, 0, 1, 1, 0)});
    vecs.push_back({1'b0, 1'b0, 1'b1, 8'h00, ex(8'h44, 0, 0, 3'd0, 0, 1, 1, 1)});
    vecs.push_back({1'b0, 1'b0, 1'b0, 8'h00, ex(8'h44, 0, 0, 3'd0, 0, 1, 1, 1)});
    vecs.push_back({1'b1, 1'b0, 1'b0, 8'h00, ex(8'h00, 0, 0, 3'd0, 0, 1, 0, 0)});
    vecs.push_back({1'b1, 1'b0, 1'b1, 8'h00, ex(8'h00, 0, 0, 3'd0, 0, 1, 0, 0)});
    vecs.push_back({1'b0, 1'b1, 1'b0, 8'h01, ex(8'h00, 1, 0, 3'd1, 0, 1, 0, 0)});
    vecs.push_back({1'b0, 1'b1, 1'b0, 8'h02, ex(8'h00, 1, 0, 3'd2, 0, 0, 0, 0)});
    vecs.push_back({1'b0, 1'b1, 1'b0, 8'h03, ex(8'h00, 1, 0, 3'd3, 1, 0, 0, 0)});
    vecs.push_back({1'b0, 1'b1, 1'b0, 8'h04, ex(8'h00, 1, 1, 3'd4, 1, 0, 0, 0)});
    vecs.push_back({1'b0, 1'b1, 1'b1, 8'h66, ex(8'h01, 1, 1, 3'd4, 1, 0, 0, 0)});
    vecs.push_back({1'b0, 1'b0, 1'b1, 8'h00, ex(8'h02, 1, 0, 3'd3, 1, 0, 0, 0)});
    vecs.push_back({1'b0, 1'b0, 1'b1, 8'h00, ex(8'h03, 1, 0, 3'd2, 0, 0, 0, 0)});
    vecs.push_back({1'b0, 1'b0, 1'b1, 8'h00, ex(8'h04, 1, 0, 3'd1, 0, 1, 0, 0)});
    vecs.push_back({1'b0, 1'b0, 1'b1, 8'h00, ex(8'h66, 0, 0, 3'd0, 0, 1, 0, 0)});
    vecs.push_back({1'b0, 1'b1, 1'b1, 8'h77, ex(8'h66, 1, 0, 3'd1, 0, 1, 0, 1)});
    vecs.push_back({1'b0, 1'b0, 1'b1, 8'h00, ex(8'h77, 0, 0, 3'd0, 0, 1, 0, 1)});
    vecs.push_back({1'b0, 1'b1, 1'b0, 8'hA1, ex(8'h77, 1, 0, 3'd1, 0, 1, 0, 1)});
    vecs.push_back({1'b0, 1'b1, 1'b0, 8'hA2, ex(8'h77, 1, 0, 3'd2, 0, 0, 0, 1)});
    vecs.push_back({1'b0, 1'b1, 1'b0, 8'hA3, ex(8'h77, 1, 0, 3'd3, 1, 0, 0, 1)});
    vecs.push_back({1'b0, 1'b1, 1'b0, 8'hA4, ex(8'h77, 1, 1, 3'd4, 1, 0, 0, 1)});
    vecs.push_back({1'b0, 1'b1, 1'b0, 8'hA5, ex(8'h77, 1, 1, 3'd4, 1, 0, 1, 1)});
    vecs.push_back({1'b0, 1'b0, 1'b1, 8'h00, ex(8'hA1, 1, 0, 3'd3, 1, 0, 1, 1)});
    vecs.push_back({1'b1, 1'b1, 1'b0, 8'h99, ex(8'h00, 0, 0, 3'd0, 0, 1, 0, 0)});

    // Reset held across two edges
    repeat (2) @(posedge clk);
    #1;
    chk("std reset", a_st, ex(8'h00, 0, 0, 3'd0, 0, 1, 0, 0));
    chk("fwft reset", b_st, ex(8'h00, 0, 0, 3'd0, 0, 1, 0, 0));
    rst_n = 1'b1;
    step();

    foreach (vecs[i]) begin
      set_a(vecs[i].clr, vecs[i].wr, vecs[i].rd, vecs[i].din);
      step();
      chk($sformatf("std vec %0d", i), a_st, vecs[i].exp);
    end
    set_a(0, 0, 0, 8'h00);

    // Wrap-around: single write/read pairs, level never above 1
    for (int i = 0; i < 20; i++) begin
      set_a(0, 1, 0, 8'(i));
      step();
      chk($sformatf("std wrap wr %0d level", i), a_lvl, 3'd1);
      set_a(0, 0, 1, 8'h00);
      step();
      chk($sformatf("std wrap rd %0d data/level", i), {a_data, a_lvl}, {8'(i), 3'd0});
    end
    set_a(0, 0, 0, 8'h00);

    // FWFT: written word visible without a read
    set_b(0, 1, 0, 8'hA5); step();
    chk("fwft wr A5", b_st, ex(8'hA5, 1, 0, 3'd1, 0, 1, 0, 0));
    set_b(0, 0, 1, 8'h00); step();
    chk("fwft pop A5", {b_en, b_lvl, b_udf}, 5'b0);
    set_b(0, 1, 0, 8'h01); step();
    chk("fwft wr 01", b_st, ex(8'h01, 1, 0, 3'd1, 0, 1, 0, 0));
    set_b(0, 1, 0, 8'h02); step();
    chk("fwft wr 02", b_st, ex(8'h01, 1, 0, 3'd2, 0, 0, 0, 0));
    set_b(0, 1, 0, 8'h03); step();
    chk("fwft wr 03", b_st, ex(8'h01, 1, 0, 3'd3, 1, 0, 0, 0));
    set_b(0, 1, 0, 8'h04); step();
    chk("fwft wr 04 full", b_st, ex(8'h01, 1, 1, 3'd4, 1, 0, 0, 0));
    set_b(0, 1, 1, 8'h66); step();
    chk("fwft full rd+wr 66", b_st, ex(8'h02, 1, 1, 3'd4, 1, 0, 0, 0));
    set_b(0, 0, 1, 8'h00); step();
    chk("fwft pop -> 03", b_st, ex(8'h03, 1, 0, 3'd3, 1, 0, 0, 0));
    step();
    chk("fwft pop -> 04", b_st, ex(8'h04, 1, 0, 3'd2, 0, 0, 0, 0));
    step();
    chk("fwft pop -> 66", b_st, ex(8'h66, 1, 0, 3'd1, 0, 1, 0, 0));
    step();
    chk("fwft pop last", {b_en, b_lvl, b_udf}, 5'b0);
    set_b(0, 1, 1, 8'h77); step();
    chk("fwft empty rd+wr 77", b_st, ex(8'h77, 1, 0, 3'd1, 0, 1, 0, 1));
    set_b(0, 1, 1, 8'h20); step();
    chk("fwft lvl1 rd+wr 20", b_st, ex(8'h20, 1, 0, 3'd1, 0, 1, 0, 1));
    set_b(0, 0, 1, 8'h00); step();
    chk("fwft pop 20", {b_en, b_lvl}, 4'b0);
    set_b(1, 0, 0, 8'h00); step();
    chk("fwft clr", b_st, ex(8'h00, 0, 0, 3'd0, 0, 1, 0, 0));
    set_b(0, 0, 0, 8'h00);

    // Async reset in the middle of a burst on both instances
    set_a(0, 1, 0, 8'h10); set_b(0, 1, 0, 8'h10); step();
    set_a(0, 1, 0, 8'h20); set_b(0, 1, 0, 8'h20); step();
    set_a(0, 1, 0, 8'h30); set_b(0, 1, 0, 8'h30);
    #2 rst_n = 1'b0;
    #1;
    chk("std async reset", a_st, ex(8'h00, 0, 0, 3'd0, 0, 1, 0, 0));
    chk("fwft async reset", b_st, ex(8'h00, 0, 0, 3'd0, 0, 1, 0, 0));
    set_a(0, 0, 0, 8'h00); set_b(0, 0, 0, 8'h00);
    step();
    rst_n = 1'b1;
    set_a(0, 1, 0, 8'h5A); set_b(0, 1, 0, 8'h5A); step();
    chk("std wr after reset", a_st, ex(8'h00, 1, 0, 3'd1, 0, 1, 0, 0));
    chk("fwft wr after reset", b_st, ex(8'h5A, 1, 0, 3'd1, 0, 1, 0, 0));
    set_a(0, 0, 1, 8'h00); set_b(0, 0, 1, 8'h00); step();
    chk("std rd after reset", {a_data, a_lvl}, {8'h5A, 3'd0});
    chk("fwft rd after reset", {b_en, b_lvl}, 4'b0);
    set_a(0, 0, 0, 8'h00); set_b(0, 0, 0, 8'h00);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_lvl.md
Name: fifo_lvl

Overview:
Parametrised synchronous FIFO, next generation of the inbox/outbox queue between the I/O interface and the CPU datapath. Adds the following:
- selectable standard or first-word-fall-through (FWFT) read mode;
- occupancy count and programmable almost-full/almost-empty flags;
- synchronous flush;
- sticky overflow/underflow error flags;
- well-defined simultaneous read/write at the full and empty boundaries.

Parameters:
B, 8, data word width in bits
W, 4, address bits; DEPTH = 2**W entries
FWFT, 0, 0 = standard read (data one cycle after i_rd); 1 = first-word-fall-through
AF_LVL, 2**W-1, o_almost_full asserted when level >= AF_LVL
AE_LVL, 1, o_almost_empty asserted when level <= AE_LVL
NAME, "", tag printed by the simulation-only trace

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_clr  in  1  synchronous flush
i_wr  in  1  write request
i_data  in  B  write data
i_rd  in  1  read request / pop
o_data  out  B  read data
o_empty_n  out  1  1 = at least one word readable
o_full  out  1  level == DEPTH
o_level  out  W+1  current occupancy, 0..DEPTH
o_almost_full  out  1  level >= AF_LVL
o_almost_empty  out  1  level <= AE_LVL
o_ovf  out  1  sticky: write dropped because full
o_udf  out  1  sticky: read requested while empty

Behaviour:
- Reset (i_rst_n=0, async): pointers=0, level=0, o_data=0, o_empty_n=0, o_full=0, o_almost_empty=1, o_almost_full=0 (unless AF_LVL=0), o_ovf=0, o_udf=0.
- Acceptance, evaluated on registered state:
  - rd_acc = i_rd & empty_n
  - wr_acc = i_wr & (~full | rd_acc)
  - Full with simultaneous rd+wr: both accepted, level unchanged.
  - Empty with simultaneous rd+wr: write only; read ignored and o_udf set.
- Level: level_next = level + wr_acc - rd_acc. Pointers wrap modulo DEPTH. Full/empty are derived from level, never from pointer equality alone.
- o_ovf sets on i_wr & ~wr_acc. o_udf sets on i_rd & ~empty_n. Both clear only on reset or i_clr.
- All status outputs are functions of registered state only; no combinational path from i_rd/i_wr to any output.
- FWFT=0:
  - On rd_acc at edge N, o_data takes the head word after edge N.
  - o_data holds its value otherwise, including across reads refused while empty.
  - o_empty_n = (level != 0).
- FWFT=1:
  - Whenever o_empty_n=1, o_data already shows the head word; rd_acc pops it, and the next word (if any) appears after the same edge.
  - A write accepted at edge N into an empty FIFO gives o_empty_n=1 and o_data=that word after edge N.
  - level counts the word held in the output stage.
  - o_data content is don't-care while o_empty_n=0.
- i_clr:
  - Has priority over i_rd/i_wr in the same cycle; both are ignored and raise no error flags.
  - After the edge: level=0, pointers=0, o_data=0, o_ovf=0, o_udf=0.
  - Memory contents are not cleared.
- Reset mid-operation discards all contents. The first write after reset release behaves as a write to empty.
- Thresholds: AF_LVL ≤ DEPTH and AE_LVL < DEPTH. An elaboration-time check under `ifndef SYNTHESIS` reports a violation.
- Simulation trace under `ifndef SYNTHESIS`: one line per change showing NAME, pointers, level and flags.

Decomposition:
- No shared package. DEPTH and the level width are localparams in the module.
- One natural sub-module, fifo_mem: simple dual-port register array, B×DEPTH, synchronous write, registered read with read-enable.
- fifo_lvl contains the pointer/level control, flags and the FWFT output stage.

Test Plan:
- W=2, FWFT=0: write 0x11,0x22,0x33,0x44 -> o_full=1, o_level=4, o_almost_full=1 (AF_LVL=3). Fifth write 0x55 -> dropped, o_ovf=1. Four reads -> o_data 0x11,0x22,0x33,0x44, each valid one cycle after its i_rd.
- W=2, FWFT=1: write 0xA5 at edge N -> after N o_empty_n=1 and o_data=0xA5 with no i_rd. Pop -> o_empty_n=0, o_level=0.
- Full plus simultaneous i_rd&i_wr of 0x66 -> o_level stays 4, o_ovf stays 0, the FIFO head advances, and 0x66 is read last.
- Empty plus simultaneous i_rd&i_wr of 0x77 -> o_level=1, o_udf=1; the next read returns 0x77.
- Wrap-around: 20 interleaved single write/read pairs with W=2, data 0..19 -> output sequence 0..19 in order, level never exceeds 1.
- i_clr asserted together with i_wr while level=3 and o_ovf=1 -> after the edge o_level=0, o_empty_n=0, o_ovf=0, o_data=0. Drop i_rst_n mid-burst -> all outputs immediately at reset values.
